pc_unit: RTL and testbench

Program-counter stage for the fetch end of the pipeline. It holds the PC register, computes the next PC from a 2-bit source select (sequential, branch, jump, return), and keeps a circular return-address stack (RAS) for call/return. Its PC output feeds instruction memory and the IF/ID register. Its select encoding is the 4-way select format used by the datapath muxes.

---
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit.sv | 106 ++++++++++
 tb/tb_pc_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Purpose : bundles the fetch-stage control/target inputs and the PC/RAS status outputs of pc_unit.
// Latency : none (wires only).
// Backpressure: stall is the only hold; the master asserts it and pc_unit freezes its state.
// Ports   : stall, pc_src[1:0], call, branch_target, jump_target (master -> slave);
//           pc, next_pc, kill, ras_empty, ras_full, ras_overflow, ras_underflow (slave -> master).
interface pc_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic                stall;
  logic [1:0]          pc_src;
  logic                call;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic                kill;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_overflow;
  logic                ras_underflow;

  // master: pipeline control driving the PC stage
  modport master (
    output stall, pc_src, call, branch_target, jump_target,
    input  pc, next_pc, kill, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  // slave: the PC stage itself
  modport slave (
    input  stall, pc_src, call, branch_target, jump_target,
    output pc, next_pc, kill, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Purpose : program counter with 4-way next-PC select and a circular return-address stack.
// Latency : pc updates one edge after next_pc is presented; next_pc and kill are combinational.
// Backpressure: stall holds pc, RAS and sticky flags; next_pc is still computed.
// Ports   : i_clk, i_rst_n (async, active low); bus (pc_unit_if.slave) carries
//           stall/pc_src/call/branch_target/jump_target in and pc/next_pc/kill/RAS status out.
module pc_unit #(
  parameter int                  PC_WIDTH  = 16,
  parameter int                  RAS_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  pc_unit_if.slave    bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_RET    = 2'd3;

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]    r_top;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_unf;

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_ras_top;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic [PTR_W-1:0]    w_top_inc;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

  // Increment wraps naturally at the register width.
  assign w_pc_inc  = r_pc + PC_WIDTH'(1);
  assign w_ras_top = r_ras[r_top];
  // Depth is a power of two, so the pointer wraps by plain overflow.
  assign w_top_inc = r_top + PTR_W'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_FULL);

  assign w_push = !bus.stall && (bus.pc_src == SRC_JUMP) && bus.call;
  assign w_pop  = !bus.stall && (bus.pc_src == SRC_RET);

  always_comb begin
    w_next_pc = w_pc_inc;
    case (bus.pc_src)
      SRC_SEQ:    w_next_pc = w_pc_inc;
      SRC_BRANCH: w_next_pc = bus.branch_target;
      SRC_JUMP:   w_next_pc = bus.jump_target;
      SRC_RET:    w_next_pc = w_empty ? w_pc_inc : w_ras_top;
      default:    w_next_pc = w_pc_inc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc  <= RESET_PC;
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
      if (w_push) begin
        r_top <= w_top_inc;
        // When full, top+1 is the oldest slot: it gets overwritten and count saturates.
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_pop) begin
        if (w_empty) begin
          r_unf <= 1'b1;
        end else begin
          r_top <= r_top - PTR_W'(1);
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Entry storage has no reset: contents are only read while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_ras[w_top_inc] <= w_pc_inc;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.next_pc       = w_next_pc;
  assign bus.kill          = !bus.stall && (bus.pc_src != SRC_SEQ);
  assign bus.ras_empty     = w_empty;
  assign bus.ras_full      = w_full;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pc_unit_if #(.PC_WIDTH(16)) bus ();

  pc_unit #(
    .PC_WIDTH (16),
    .RAS_DEPTH(DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC as a number, RAS as a bounded LIFO queue (newest at back).
  logic [15:0] m_pc;
  logic [15:0] m_ras [$];
  logic        m_ovf;
  logic        m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic check_regs();
    chk("pc", bus.pc, m_pc);
    chk("ras_empty", bus.ras_empty, (m_ras.size() == 0));
    chk("ras_full", bus.ras_full, (m_ras.size() == DEPTH));
    chk("ras_overflow", bus.ras_overflow, m_ovf);
    chk("ras_underflow", bus.ras_underflow, m_unf);
  endtask

  // Called just after a rising edge: drive inputs, check combinational outputs
  // mid-cycle, advance the model at the edge, then check registered state.
  task automatic step(input logic st, input logic [1:0] src, input logic cl,
                      input logic [15:0] bt, input logic [15:0] jt,
                      output logic [15:0] o_next, output logic o_kill);
    logic [15:0] seq;
    logic [15:0] exp_next;
    bus.stall = st;
    bus.pc_src = src;
    bus.call = cl;
    bus.branch_target = bt;
    bus.jump_target = jt;
    seq = 16'((int'(m_pc) + 1) % 65536);
    case (src)
      2'd0:    exp_next = seq;
      2'd1:    exp_next = bt;
      2'd2:    exp_next = jt;
      default: exp_next = (m_ras.size() > 0) ? m_ras[$] : seq;
    endcase
    @(negedge clk);
    o_next = bus.next_pc;
    o_kill = bus.kill;
    chk("next_pc", bus.next_pc, exp_next);
    chk("kill", bus.kill, (!st && src != 2'd0));
    @(posedge clk);
    if (!st) begin
      if (src == 2'd2 && cl) begin
        if (m_ras.size() == DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(seq);
      end else if (src == 2'd3) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
        else m_unf = 1'b1;
      end
      m_pc = exp_next;
    end
    #1;
    check_regs();
  endtask

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic        call;
    logic [15:0] bt;
    logic [15:0] jt;
    logic        exp_kill;
    logic [15:0] exp_next;
    logic [15:0] exp_pc;
    logic        exp_empty;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [1:0] src, input logic cl,
                              input logic [15:0] bt, input logic [15:0] jt, input logic k,
                              input logic [15:0] nx, input logic [15:0] p, input logic e);
    vec_t v;
    v.stall = st; v.src = src; v.call = cl; v.bt = bt; v.jt = jt;
    v.exp_kill = k; v.exp_next = nx; v.exp_pc = p; v.exp_empty = e;
    return v;
  endfunction

  vec_t tv [17];

  // Watchdog: the bench never waits on a DUT event, but bound the run anyway.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] nx;
    logic        k;
    logic [15:0] ret;

    // 5 increments from reset, jump to 3, branch, stalled jump, call/return pair.
    for (int i = 0; i < 5; i++)
      tv[i] = mk(0, 2'd0, 0, 16'h0, 16'h0, 0, 16'(i + 1), 16'(i + 1), 1);
    tv[5]  = mk(0, 2'd2, 0, 16'h0,    16'h0003, 1, 16'h0003, 16'h0003, 1);
    tv[6]  = mk(0, 2'd1, 0, 16'h0040, 16'h0,    1, 16'h0040, 16'h0040, 1);
    tv[7]  = mk(1, 2'd2, 0, 16'h0,    16'h0100, 0, 16'h0100, 16'h0040, 1);
    tv[8]  = mk(0, 2'd2, 0, 16'h0,    16'h0100, 1, 16'h0100, 16'h0100, 1);
    tv[9]  = mk(0, 2'd1, 0, 16'h0010, 16'h0,    1, 16'h0010, 16'h0010, 1);
    tv[10] = mk(0, 2'd2, 1, 16'h0,    16'h0200, 1, 16'h0200, 16'h0200, 0);
    for (int i = 0; i < 5; i++)
      tv[11 + i] = mk(0, 2'd0, 0, 16'h0, 16'h0, 0, 16'(16'h0201 + i), 16'(16'h0201 + i), 0);
    tv[16] = mk(0, 2'd3, 0, 16'h0, 16'h0, 1, 16'h0011, 16'h0011, 1);

    // Reset state
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.pc_src = 2'd0;
    bus.call = 1'b0;
    bus.branch_target = '0;
    bus.jump_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, 16'h0000);
    chk("reset_kill", bus.kill, 1'b0);
    check_regs();
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      step(tv[i].stall, tv[i].src, tv[i].call, tv[i].bt, tv[i].jt, nx, k);
      chk($sformatf("tv%0d_next", i), nx, tv[i].exp_next);
      chk($sformatf("tv%0d_kill", i), k, tv[i].exp_kill);
      chk($sformatf("tv%0d_pc", i), bus.pc, tv[i].exp_pc);
      chk($sformatf("tv%0d_empty", i), bus.ras_empty, tv[i].exp_empty);
    end

    // Overflow: 9 nested calls from pc=0x0011, then 8 returns in LIFO order.
    for (int i = 1; i <= 9; i++) begin
      step(0, 2'd2, 1, 16'h0, 16'(16'h1000 + i * 16'h0100), nx, k);
      chk("ovf_call_pc", bus.pc, 16'(16'h1000 + i * 16'h0100));
      if (i == 8) begin
        chk("ovf_full8", bus.ras_full, 1'b1);
        chk("ovf_flag8", bus.ras_overflow, 1'b0);
      end
      if (i == 9) chk("ovf_flag9", bus.ras_overflow, 1'b1);
    end
    for (int j = 0; j < 8; j++) begin
      // Call n was issued at pc 0x1000+(n-1)*0x100, so it pushed that value +1.
      ret = 16'(16'h1000 + (8 - j) * 16'h0100 + 1);
      step(0, 2'd3, 0, 16'h0, 16'h0, nx, k);
      chk("ovf_ret_pc", bus.pc, ret);
    end
    chk("ovf_end_empty", bus.ras_empty, 1'b1);
    chk("ovf_sticky", bus.ras_overflow, 1'b1);

    // Underflow at pc=0x0007
    step(0, 2'd2, 0, 16'h0, 16'h0007, nx, k);
    step(0, 2'd3, 0, 16'h0, 16'h0, nx, k);
    chk("unf_next", nx, 16'h0008);
    chk("unf_flag", bus.ras_underflow, 1'b1);
    repeat (3) step(0, 2'd0, 0, 16'h0, 16'h0, nx, k);
    chk("unf_sticky", bus.ras_underflow, 1'b1);

    // Wrap at all-ones
    step(0, 2'd2, 0, 16'h0, 16'hFFFF, nx, k);
    step(0, 2'd0, 0, 16'h0, 16'h0, nx, k);
    chk("wrap_pc", bus.pc, 16'h0000);

    // Async reset mid-call: pc reloads with no clock edge, push is discarded.
    step(0, 2'd1, 0, 16'h0123, 16'h0, nx, k);
    bus.stall = 1'b0;
    bus.pc_src = 2'd2;
    bus.call = 1'b1;
    bus.jump_target = 16'h0500;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pc", bus.pc, 16'h0000);
    chk("arst_empty", bus.ras_empty, 1'b1);
    chk("arst_unf", bus.ras_underflow, 1'b0);
    chk("arst_ovf", bus.ras_overflow, 1'b0);
    @(posedge clk);
    #1;
    check_regs();
    rst_n = 1'b1;
    step(0, 2'd0, 0, 16'h0, 16'h0, nx, k);
    chk("arst_first_pc", bus.pc, 16'h0001);
    chk("arst_no_push", bus.ras_empty, 1'b1);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom), nx, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
